// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
// Shared types and constants for the processor control FSM (control_fsm).
//   state_t   : controller state encoding, also exported on the State port
//   opcode_t  : instruction opcodes held in IR[15:12]
//   ALU_*     : ALU operation select codes driven on ALU_s0
//   IR_*_LSB  : least-significant bit positions of the instruction fields
// ----------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_LOAD_A = 4'd4,
        ST_LOAD_B = 4'd5,
        ST_STORE  = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'd0,
        OP_STORE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_HALT  = 4'd5
    } opcode_t;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

    // Instruction field positions (LSB of each field)
    localparam int unsigned IR_OP_LSB      = 12; // opcode            IR[15:12]
    localparam int unsigned IR_RA_LSB      = 8;  // source A / store  IR[11:8]
    localparam int unsigned IR_RB_LSB      = 4;  // source B          IR[7:4]
    localparam int unsigned IR_RD_LSB      = 0;  // destination       IR[3:0]
    localparam int unsigned IR_LD_ADDR_LSB = 4;  // LOAD mem address  IR[11:4]
    localparam int unsigned IR_ST_ADDR_LSB = 0;  // STORE mem address IR[7:0]

endpackage

// File: rtl/control_fsm.sv
// ----------------------------------------------------------------------------
// control_fsm
// Moore controller for the 16-bit processor. Runs fetch / decode / execute for
// each instruction held in the instruction register, one instruction at a
// time. Outputs are decoded from the state register and IR fields only.
//
// Ports:
//   Clk         in   system clock (posedge)
//   ResetN      in   asynchronous active-low reset; forces INIT
//   IR          in   instruction register output
//   PC_clr      out  clear program counter (INIT)
//   PC_up       out  increment program counter (FETCH)
//   IR_ld       out  instruction register load enable (FETCH)
//   D_addr      out  data-memory address
//   D_wr        out  data-memory write enable (STORE)
//   RF_s        out  register-file write source: 1 = memory, 0 = ALU
//   RF_W_addr   out  register-file write address
//   RF_W_en     out  register-file write enable
//   RF_Ra_addr  out  register-file read port A address
//   RF_Rb_addr  out  register-file read port B address
//   ALU_s0      out  ALU select (pass/add/sub)
//   Halted      out  high in HALT
//   State       out  current state encoding (debug)
//   Illegal     out  only with CTRL_ILLEGAL_TRAP_EN: sticky illegal-opcode flag
//
// Build option: define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes into HALT
// and expose the Illegal port; otherwise illegal opcodes execute as NOOP.
// ----------------------------------------------------------------------------
module control_fsm
    import ctrl_pkg::*;
#(
    parameter int unsigned OP_W      = 4,
    parameter int unsigned D_ADDR_W  = 8,
    parameter int unsigned RF_ADDR_W = 4
) (
    input  logic                 Clk,
    input  logic                 ResetN,
    input  logic [15:0]          IR,
    output logic                 PC_clr,
    output logic                 PC_up,
    output logic                 IR_ld,
    output logic [D_ADDR_W-1:0]  D_addr,
    output logic                 D_wr,
    output logic                 RF_s,
    output logic [RF_ADDR_W-1:0] RF_W_addr,
    output logic                 RF_W_en,
    output logic [RF_ADDR_W-1:0] RF_Ra_addr,
    output logic [RF_ADDR_W-1:0] RF_Rb_addr,
    output logic [2:0]           ALU_s0,
    output logic                 Halted,
    output logic [3:0]           State
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic                 Illegal
`endif
);

    state_t state_q, state_d;

    logic [OP_W-1:0]      op;
    logic [RF_ADDR_W-1:0] ra_f, rb_f, rd_f;
    logic [D_ADDR_W-1:0]  ld_addr_f, st_addr_f;

    assign op        = IR[IR_OP_LSB      +: OP_W];
    assign ra_f      = IR[IR_RA_LSB      +: RF_ADDR_W];
    assign rb_f      = IR[IR_RB_LSB      +: RF_ADDR_W];
    assign rd_f      = IR[IR_RD_LSB      +: RF_ADDR_W];
    assign ld_addr_f = IR[IR_LD_ADDR_LSB +: D_ADDR_W];
    assign st_addr_f = IR[IR_ST_ADDR_LSB +: D_ADDR_W];

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q   <= ST_INIT;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        unique case (state_q)
            ST_INIT:   state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode_t'(op))
                    OP_NOOP:  state_d = ST_NOOP;
                    OP_STORE: state_d = ST_STORE;
                    OP_LOAD:  state_d = ST_LOAD_A;
                    OP_ADD:   state_d = ST_ADD;
                    OP_SUB:   state_d = ST_SUB;
                    OP_HALT:  state_d = ST_HALT;
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_d   = ST_HALT;
                        illegal_d = 1'b1;
`else
                        state_d   = ST_NOOP;
`endif
                    end
                endcase
            end
            ST_LOAD_A: state_d = ST_LOAD_B;
            ST_NOOP,
            ST_LOAD_B,
            ST_STORE,
            ST_ADD,
            ST_SUB:    state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            // Unused encodings recover through INIT
            default:   state_d = ST_INIT;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Moore: state register plus IR fields)
    // ------------------------------------------------------------------
    always_comb begin
        PC_clr     = 1'b0;
        PC_up      = 1'b0;
        IR_ld      = 1'b0;
        D_addr     = '0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = '0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = '0;
        RF_Rb_addr = '0;
        ALU_s0     = ALU_PASS;
        Halted     = 1'b0;
        State      = state_q;
        unique case (state_q)
            ST_INIT:   PC_clr = 1'b1;
            ST_FETCH: begin
                IR_ld = 1'b1;
                PC_up = 1'b1;
            end
            // LOAD_A holds the address for the synchronous memory read;
            // LOAD_B keeps it and writes the returned data.
            ST_LOAD_A: begin
                D_addr = ld_addr_f;
                RF_s   = 1'b1;
            end
            ST_LOAD_B: begin
                D_addr    = ld_addr_f;
                RF_s      = 1'b1;
                RF_W_addr = rd_f;
                RF_W_en   = 1'b1;
            end
            ST_STORE: begin
                D_addr     = st_addr_f;
                RF_Ra_addr = ra_f;
                D_wr       = 1'b1;
            end
            ST_ADD, ST_SUB: begin
                RF_Ra_addr = ra_f;
                RF_Rb_addr = rb_f;
                RF_W_addr  = rd_f;
                RF_W_en    = 1'b1;
                ALU_s0     = (state_q == ST_ADD) ? ALU_ADD : ALU_SUB;
            end
            ST_HALT:   Halted = 1'b1;
            default: ;
        endcase
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign Illegal = illegal_q;
`endif

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;
    import ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ir = 16'h0000;

    logic        pc_clr, pc_up, ir_ld, d_wr, rf_s, rf_w_en, halted;
    logic [7:0]  d_addr;
    logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr, state;
    logic [2:0]  alu_s0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    control_fsm #(.OP_W(4), .D_ADDR_W(8), .RF_ADDR_W(4)) dut (
        .Clk(clk), .ResetN(rst_n), .IR(ir),
        .PC_clr(pc_clr), .PC_up(pc_up), .IR_ld(ir_ld),
        .D_addr(d_addr), .D_wr(d_wr), .RF_s(rf_s),
        .RF_W_addr(rf_w_addr), .RF_W_en(rf_w_en),
        .RF_Ra_addr(rf_ra_addr), .RF_Rb_addr(rf_rb_addr),
        .ALU_s0(alu_s0), .Halted(halted), .State(state)
`ifdef CTRL_ILLEGAL_TRAP_EN
        , .Illegal(illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_clr, pc_up, ir_ld;
        logic [7:0] d_addr;
        logic       d_wr, rf_s;
        logic [3:0] wa;
        logic       wen;
        logic [3:0] ra, rb;
        logic [2:0] alu;
        logic       halted;
    } exp_t;

    typedef struct {
        logic [15:0] ir;
        int unsigned lat;
        exp_t        x1;
        exp_t        x2;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    vec_t tbl[$];

    function automatic exp_t sample();
        exp_t a;
        a.st = state; a.pc_clr = pc_clr; a.pc_up = pc_up; a.ir_ld = ir_ld;
        a.d_addr = d_addr; a.d_wr = d_wr; a.rf_s = rf_s; a.wa = rf_w_addr;
        a.wen = rf_w_en; a.ra = rf_ra_addr; a.rb = rf_rb_addr; a.alu = alu_s0;
        a.halted = halted;
        return a;
    endfunction

    task automatic check(input string name, input exp_t e);
        exp_t a;
        a = sample();
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, a, e);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, want);
        end
    endtask

    function automatic exp_t ex(state_t st, logic [7:0] da, logic dwr, logic rfs,
                                logic [3:0] wa, logic wen, logic [3:0] ra,
                                logic [3:0] rb, logic [2:0] alu);
        exp_t e;
        e = '0;
        e.st = st; e.d_addr = da; e.d_wr = dwr; e.rf_s = rfs; e.wa = wa;
        e.wen = wen; e.ra = ra; e.rb = rb; e.alu = alu;
        return e;
    endfunction

    function automatic exp_t init_rec();
        exp_t e;
        e = '0; e.st = ST_INIT; e.pc_clr = 1'b1;
        return e;
    endfunction

    function automatic exp_t fetch_rec();
        exp_t e;
        e = '0; e.st = ST_FETCH; e.ir_ld = 1'b1; e.pc_up = 1'b1;
        return e;
    endfunction

    function automatic exp_t halt_rec();
        exp_t e;
        e = '0; e.st = ST_HALT; e.halted = 1'b1;
        return e;
    endfunction

    // Reference model: per-cycle expectations for one instruction, derived
    // from its architectural effect (which registers/memory it touches and
    // whether memory read latency adds a cycle).
    function automatic void model_push(input logic [15:0] instr);
        logic [3:0] op;
        logic       mem_rd, mem_wr, reg_wr;
        exp_t       e;
        op     = instr[15:12];
        mem_rd = (op == 4'd2);
        mem_wr = (op == 4'd1);
        reg_wr = (op >= 4'd2) && (op <= 4'd4);
        exp_q.push_back(fetch_rec());
        e = '0; e.st = ST_DECODE;
        exp_q.push_back(e);
        e = '0;
        if (mem_wr) begin
            e.st = ST_STORE; e.d_addr = instr[7:0]; e.ra = instr[11:8]; e.d_wr = 1'b1;
            exp_q.push_back(e);
        end else if (mem_rd) begin
            e.st = ST_LOAD_A; e.d_addr = instr[11:4]; e.rf_s = 1'b1;
            exp_q.push_back(e);
            e.st = ST_LOAD_B; e.wa = instr[3:0]; e.wen = 1'b1;
            exp_q.push_back(e);
        end else if (reg_wr) begin
            e.st  = (op == 4'd3) ? ST_ADD : ST_SUB;
            e.ra  = instr[11:8]; e.rb = instr[7:4]; e.wa = instr[3:0]; e.wen = 1'b1;
            e.alu = (op == 4'd3) ? 3'd1 : 3'd2;
            exp_q.push_back(e);
        end else begin
            e.st = ST_NOOP;
            exp_q.push_back(e);
        end
    endfunction

    // Hold reset for 3 cycles, release, and leave the bench at the
    // falling edge inside the first FETCH.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("reset_hold", init_rec());
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        check_bit("reset_illegal", illegal, 1'b0);
`endif
        rst_n = 1'b1;
        #1 check("reset_release_init", init_rec());
        @(negedge clk);
        check("reset_first_fetch", fetch_rec());
    endtask

    task automatic run_vec(input vec_t v);
        exp_t d;
        d = '0; d.st = ST_DECODE;
        ir = v.ir;
        check("vec_fetch", fetch_rec());
        @(negedge clk); check("vec_decode", d);
        @(negedge clk); check("vec_exec1", v.x1);
        if (v.lat == 4) begin
            @(negedge clk); check("vec_exec2", v.x2);
        end
        @(negedge clk); check("vec_refetch", fetch_rec());
    endtask

    initial begin
        vec_t v;
        exp_t e;
        logic [15:0] r;

        v.ir = 16'h3123; v.lat = 3; v.x1 = ex(ST_ADD, 8'h00, 0, 0, 4'h3, 1, 4'h1, 4'h2, 3'd1); v.x2 = '0; tbl.push_back(v);
        v.ir = 16'h4A5C; v.lat = 3; v.x1 = ex(ST_SUB, 8'h00, 0, 0, 4'hC, 1, 4'hA, 4'h5, 3'd2); v.x2 = '0; tbl.push_back(v);
        v.ir = 16'h2AB5; v.lat = 4; v.x1 = ex(ST_LOAD_A, 8'hAB, 0, 1, 4'h0, 0, 4'h0, 4'h0, 3'd0);
                                    v.x2 = ex(ST_LOAD_B, 8'hAB, 0, 1, 4'h5, 1, 4'h0, 4'h0, 3'd0); tbl.push_back(v);
        v.ir = 16'h1742; v.lat = 3; v.x1 = ex(ST_STORE, 8'h42, 1, 0, 4'h0, 0, 4'h7, 4'h0, 3'd0); v.x2 = '0; tbl.push_back(v);
        v.ir = 16'h0FFF; v.lat = 3; v.x1 = ex(ST_NOOP, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0); v.x2 = '0; tbl.push_back(v);
        v.ir = 16'h20F0; v.lat = 4; v.x1 = ex(ST_LOAD_A, 8'h0F, 0, 1, 4'h0, 0, 4'h0, 4'h0, 3'd0);
                                    v.x2 = ex(ST_LOAD_B, 8'h0F, 0, 1, 4'h0, 1, 4'h0, 4'h0, 3'd0); tbl.push_back(v);
`ifndef CTRL_ILLEGAL_TRAP_EN
        v.ir = 16'hF000; v.lat = 3; v.x1 = ex(ST_NOOP, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0); v.x2 = '0; tbl.push_back(v);
        v.ir = 16'h6123; v.lat = 3; v.x1 = ex(ST_NOOP, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0); v.x2 = '0; tbl.push_back(v);
`endif

        // Directed table
        do_reset();
        foreach (tbl[i]) run_vec(tbl[i]);

        // STORE asserts D_wr for exactly one cycle
        ir = 16'h1742;
        @(negedge clk); check_bit("store_dwr_decode", d_wr, 1'b0);
        @(negedge clk); check_bit("store_dwr_exec", d_wr, 1'b1);
        @(negedge clk); check_bit("store_dwr_after", d_wr, 1'b0);

        // HALT persists for 20 cycles regardless of IR
        ir = 16'h5000;
        check("halt_fetch", fetch_rec());
        @(negedge clk);
        repeat (20) begin
            @(negedge clk);
            check("halt_hold", halt_rec());
            r = 16'($urandom);
            ir = r;
        end

`ifdef CTRL_ILLEGAL_TRAP_EN
        do_reset();
        ir = 16'hF000;
        @(negedge clk);
        @(negedge clk);
        check("trap_halt", halt_rec());
        check_bit("trap_illegal", illegal, 1'b1);
        repeat (3) @(negedge clk);
        check("trap_hold", halt_rec());
        check_bit("trap_illegal_hold", illegal, 1'b1);
`endif

        // Asynchronous reset in the middle of STORE
        do_reset();
        ir = 16'h1742;
        @(negedge clk);
        @(negedge clk);
        check("mid_store_before", ex(ST_STORE, 8'h42, 1, 0, 4'h0, 0, 4'h7, 4'h0, 3'd0));
        #2 rst_n = 1'b0;
        #1 check("mid_store_async_rst", init_rec());

        // Randomized instructions against the reference model
        do_reset();
        for (int n = 0; n < 300; n++) begin
            r = 16'($urandom);
`ifdef CTRL_ILLEGAL_TRAP_EN
            if (r[15:12] >= 4'd5) r[15:12] = 4'($urandom_range(0, 4));
`else
            if (r[15:12] == 4'd5) r[15:12] = 4'($urandom_range(0, 4));
`endif
            exp_q.delete();
            model_push(r);
            ir = r;
            foreach (exp_q[k]) begin
                check("rand", exp_q[k]);
                @(negedge clk);
            end
        end
        e = fetch_rec();
        check("rand_end_fetch", e);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Moore controller for the 16-bit processor; the downstream consumer of the instruction register output.
- Sequences fetch, decode and execute for each instruction held in the instruction register.
- Drives program counter clear/increment, the instruction register load enable, data-memory address/write, register-file addresses/enables and ALU select.
- One instruction per fetch; no pipelining.

Parameters:
- OP_W, 4, opcode width (IR[15:12])
- D_ADDR_W, 8, data-memory address width
- RF_ADDR_W, 4, register-file address width

Ports:
- Clk  input  1  system clock; all state updates on posedge
- ResetN  input  1  asynchronous, active-low reset
- IR  input  16  instruction from the instruction register output
- PC_clr  output  1  clear program counter
- PC_up  output  1  increment program counter
- IR_ld  output  1  instruction register load enable (drives its Id input)
- D_addr  output  D_ADDR_W  data-memory address
- D_wr  output  1  data-memory write enable
- RF_s  output  1  register-file write source: 1 = data memory, 0 = ALU
- RF_W_addr  output  RF_ADDR_W  register-file write address
- RF_W_en  output  1  register-file write enable
- RF_Ra_addr  output  RF_ADDR_W  register-file read port A address
- RF_Rb_addr  output  RF_ADDR_W  register-file read port B address
- ALU_s0  output  3  ALU op select: 0 = pass-through, 1 = add, 2 = sub
- Halted  output  1  high in HALT
- State  output  4  current state encoding, for debug

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-low on ResetN. While ResetN = 0, state = INIT.
- Outputs: every output is decoded from the state register and IR fields only, with no combinational input-to-state feedback. Every output defaults to 0 in every state unless listed below. Reset output values are therefore the INIT values: PC_clr = 1, all else 0, State = INIT.
- Instruction encoding (IR[15:12]):
  - NOOP = 0
  - STORE = 1: D[IR[7:0]] <= R[IR[11:8]]
  - LOAD = 2: R[IR[3:0]] <= D[IR[11:4]]
  - ADD = 3: R[IR[3:0]] <= R[IR[11:8]] + R[IR[7:4]]
  - SUB = 4: R[IR[3:0]] <= R[IR[11:8]] - R[IR[7:4]]
  - HALT = 5
  - 6..15 illegal
- State transitions:
  - INIT: PC_clr = 1 -> FETCH
  - FETCH: IR_ld = 1, PC_up = 1 -> DECODE. The instruction memory output at the old PC is captured into the IR on this edge.
  - DECODE: no outputs. Next state by opcode: NOOP, LOAD_A, STORE, ADD, SUB, HALT; illegal -> NOOP.
  - NOOP -> FETCH
  - LOAD_A: D_addr = IR[11:4], RF_s = 1 -> LOAD_B. Covers the synchronous data-memory read latency.
  - LOAD_B: D_addr = IR[11:4], RF_s = 1, RF_W_addr = IR[3:0], RF_W_en = 1 -> FETCH
  - STORE: D_addr = IR[7:0], RF_Ra_addr = IR[11:8], D_wr = 1 -> FETCH
  - ADD: RF_Ra_addr = IR[11:8], RF_Rb_addr = IR[7:4], RF_W_addr = IR[3:0], ALU_s0 = 1, RF_s = 0, RF_W_en = 1 -> FETCH
  - SUB: as ADD with ALU_s0 = 2 -> FETCH
  - HALT: Halted = 1. Self-loop; exits only via reset.
- Latency (cycles from FETCH entry back to next FETCH): NOOP, STORE, ADD and SUB = 3; LOAD = 4; INIT->FETCH = 1 cycle after ResetN release.
- IR stability: IR_ld is high only in FETCH, so IR is constant from DECODE through execute.
- Unused state encodings: any unused State encoding -> INIT on next edge.
- Reset mid-instruction: any in-flight D_wr or RF_W_en deasserts immediately (asynchronous). The partial instruction is abandoned and PC_clr asserts.

Optional Feature:
- CTRL_ILLEGAL_TRAP_EN defined:
  - Illegal opcodes in DECODE -> HALT.
  - Extra output Illegal (1 bit) is set on that transition and held until reset.
- Undefined: illegal opcodes execute as NOOP and the Illegal port is absent.

Decomposition:
- Package ctrl_pkg holds:
  - state_t enum (INIT, FETCH, DECODE, NOOP, LOAD_A, LOAD_B, STORE, ADD, SUB, HALT)
  - opcode_t enum
  - ALU select constants ALU_PASS, ALU_ADD, ALU_SUB
  - IR field bit-position localparams
- No sub-module: the next-state and output decode are single always_ff/always_comb blocks within control_fsm.

Test Plan:
- Reset: hold ResetN = 0 for 3 cycles -> State = INIT, PC_clr = 1, all other outputs 0. Release -> FETCH next edge with IR_ld = 1 and PC_up = 1.
- ADD: IR = 16'h3123 -> DECODE then ADD. In ADD: Ra = 1, Rb = 2, W_addr = 3, ALU_s0 = 1, RF_W_en = 1. Returns to FETCH 3 cycles after FETCH entry.
- LOAD: IR = 16'h2AB5 -> LOAD_A with D_addr = 8'hAB, then LOAD_B with RF_W_en = 1, W_addr = 5, RF_s = 1, then FETCH.
- STORE: IR = 16'h1742 -> STORE with D_addr = 8'h42, RF_Ra_addr = 7, D_wr = 1 for exactly one cycle.
- HALT and illegal opcode:
  - IR = 16'h5000 -> Halted = 1 and stays there for 20 cycles; IR_ld stays 0.
  - IR = 16'hF000 -> NOOP then FETCH. With CTRL_ILLEGAL_TRAP_EN defined, goes to HALT with Illegal = 1.
- Reset during STORE: drive ResetN = 0 mid-cycle -> D_wr drops to 0 without waiting for a clock edge and State = INIT.
